// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: queue entry payload, state encoding, PC helpers.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between imem responses and decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch.sv
// Fetch stage: credit-limited in-order imem requests, redirect with response draining.
// Optional same-cycle response bypass to decode under FETCH_BYPASS_EN.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  fetch_entry_t  q_in, q_head;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty;
  logic          credit_ok, accept, resp_hit, resp_keep, bypass, push, pop;
  logic          unused_ok;

  assign credit_ok      = (SW'(out_q) + SW'(q_count)) < SW'(QDEPTH);
  assign imem_req_valid = !rst && (state_q == RUN) && credit_ok;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign resp_hit  = !rst && imem_resp_valid && (out_q != '0);
  assign resp_keep = resp_hit && !redirect_valid && (drop_q == '0);

  // Kept responses only occur in an unbroken run, so the oldest tag is pc - 4*outstanding.
  assign q_in = '{pc: pc_q - (32'(out_q) << 2), instr: imem_resp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_keep && !(bypass && instr_ready);
  assign pop  = !redirect_valid && !q_empty && instr_ready;

  assign instr_valid = !rst && (!q_empty || bypass);
  assign instr       = !instr_valid ? '0 : (bypass ? q_in.instr : q_head.instr);
  assign instr_pc    = !instr_valid ? '0 : (bypass ? q_in.pc    : q_head.pc);

  assign unused_ok = q_full;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    out_d   = out_q + CW'(accept) - CW'(resp_hit);
    if (redirect_valid) begin
      pc_d   = align_word(redirect_pc);
      drop_d = out_d;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (resp_hit && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (q_in),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch against a stream-level reference model.
module tb_fetch;

  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  // Reference state: memory pipeline contents plus the expected request and delivery streams.
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          stale = 0;
  int          drop = 0;
  int          queued = 0;
  int          n_del = 0;
  logic [31:0] pq_addr[$];
  int          pq_step[$];
  logic [31:0] exp_req = RPC;
  logic [31:0] exp_ipc = RPC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst             = 1'b1;
      imem_req_ready  = 1'($urandom_range(1));
      instr_ready     = 1'($urandom_range(1));
      imem_resp_valid = 1'($urandom_range(1));
      imem_resp_data  = $urandom;
      redirect_valid  = 1'($urandom_range(1));
      redirect_pc     = $urandom;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      cyc++;
    end
    stale   = pq_addr.size();
    queued  = 0;
    drop    = 0;
    exp_req = RPC;
    exp_ipc = RPC;
  endtask

  task automatic step(input int p_rr, input int p_ir, input int p_rsp,
                      input bit redir_in, input logic [31:0] rpc);
    bit   redir, rsp, rsp_live, exp_rv, exp_iv, acc, cons;
    int   live;
    redir = redir_in && (stale == 0);
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = ($urandom_range(99) < p_rr) && (stale == 0);
    instr_ready    = ($urandom_range(99) < p_ir);
    rsp = (pq_addr.size() > 0) && ((stale > 0) || (pq_step[0] < cyc))
          && ($urandom_range(99) < p_rsp);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mem_word(pq_addr[0]) : $urandom;
    redirect_valid  = redir;
    redirect_pc     = redir ? rpc : $urandom;
    #1;
    live     = pq_addr.size() - stale;
    rsp_live = rsp && (stale == 0) && !redir && (drop == 0);
    exp_rv   = (drop == 0) && ((live + queued) < int'(QD));
    exp_iv   = (queued > 0) || (BYP && rsp_live);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("instr_pc", instr_pc, exp_ipc);
      chk("instr", instr, mem_word(exp_ipc));
    end
    acc  = exp_rv && imem_req_ready;
    cons = exp_iv && instr_ready;
    if (acc) begin
      pq_addr.push_back(exp_req);
      pq_step.push_back(cyc);
    end
    if (rsp) begin
      void'(pq_addr.pop_front());
      void'(pq_step.pop_front());
      if (stale > 0) stale--;
      else if (!redir && (drop > 0)) drop--;
    end
    if (rsp_live) queued++;
    if (cons) begin
      queued--;
      n_del++;
      exp_ipc = exp_ipc + 32'd4;
    end
    if (redir) begin
      queued  = 0;
      drop    = pq_addr.size() - stale;
      exp_req = {rpc[31:2], 2'b00};
      exp_ipc = {rpc[31:2], 2'b00};
    end else if (acc) begin
      exp_req = exp_req + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    instr_ready     = 1'b0;

    do_reset(2);

    // Full-rate streaming.
    for (int i = 0; i < 20; i++) step(100, 100, 100, 1'b0, 32'h0);
    // Decode stalled, then released.
    for (int i = 0; i < 10; i++) step(100, 0, 100, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(100, 100, 100, 1'b0, 32'h0);
    // Build up outstanding requests, then redirect to 0x100.
    for (int i = 0; i < 2; i++) step(100, 100, 0, 1'b0, 32'h0);
    step(0, 100, 0, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 12; i++) step(100, 100, 100, 1'b0, 32'h0);
    // Unaligned redirect target.
    step(100, 100, 100, 1'b1, 32'h0000_0203);
    for (int i = 0; i < 10; i++) step(100, 100, 100, 1'b0, 32'h0);
    // Address wrap past 0xFFFF_FFFC.
    step(100, 100, 100, 1'b1, 32'hFFFF_FFF2);
    for (int i = 0; i < 14; i++) step(100, 100, 100, 1'b0, 32'h0);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 600; i++)
      step($urandom_range(100), $urandom_range(100), $urandom_range(100),
           ($urandom_range(99) < 4), $urandom);

    // Reset with requests in flight; stale responses must be ignored.
    do_reset(2);
    for (int i = 0; i < 8; i++) step(100, 100, 100, 1'b0, 32'h0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100),
           ($urandom_range(99) < 3), (i % 2 == 0) ? $urandom : 32'hFFFF_FFF0);

    chk("deliveries", 32'(n_del >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
